// File: rtl/router_pkg.sv
// router_pkg: shared definitions for the router input-port queueing logic.
//   - DATA_W_DEFAULT : default flit width
//   - flit_t         : flit type at the default width
//   - calc_vc_w / calc_ptr_w / calc_cnt_w : derived field widths
package router_pkg;

  localparam int DATA_W_DEFAULT = 64;

  typedef logic [DATA_W_DEFAULT-1:0] flit_t;

  // VC select width; a single-VC bank still carries a 1-bit select.
  function automatic int calc_vc_w(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

  function automatic int calc_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so a completely full VC (count == depth) is representable.
  function automatic int calc_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vc_fifo_ctrl.sv
// vc_fifo_ctrl: bookkeeping for one virtual channel of the shared FIFO bank.
// Holds head/tail pointers and occupancy; storage lives in the parent.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wr_acc        a write to this VC is accepted this cycle
//   rd_acc        a read from this VC is accepted this cycle
//   head, tail    read / write pointers into this VC's slice of storage
//   count         occupancy
//   full, empty, almost_full   status derived from the count register
module vc_fifo_ctrl
  import router_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  localparam int PTR_W    = calc_ptr_w(DEPTH),
  localparam int CNT_W    = calc_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_acc,
  input  logic             rd_acc,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full
);

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  // Simultaneous accepted read and write leave occupancy unchanged.
  always_comb begin
    count_next = count_reg;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (rd_acc) head_reg <= head_reg + PTR_W'(1);
      if (wr_acc) tail_reg <= tail_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  // Status comes only from the count register, never from the request
  // inputs, so backpressure outputs have no combinational path from wr_en.
  assign head        = head_reg;
  assign tail        = tail_reg;
  assign count       = count_reg;
  assign full        = (count_reg == CNT_W'(DEPTH));
  assign empty       = (count_reg == '0);
  assign almost_full = (count_reg >= CNT_W'(AF_THRESH));

endmodule

// File: rtl/vc_fifo_bank.sv
// vc_fifo_bank: NUM_VC independent FIFOs sharing one storage array.
// One write and one read per cycle, each steered by a VC select.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   wr_en, wr_vc, wr_data      write request, target VC, flit
//   rd_en, rd_vc               pop request, VC selected for pop and rd_data
//   rd_data, rd_valid          show-ahead head flit of rd_vc (combinational)
//   full, empty, almost_full   per-VC status bits
//   count                      per-VC occupancy, VC v at [v*CNT_W +: CNT_W]
//   err_clr                    clears the sticky error flags
//   err_overflow               sticky: a write was dropped
//   err_underflow              sticky: a read found nothing to pop
module vc_fifo_bank
  import router_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int DEPTH     = 8,
  parameter int NUM_VC    = 4,
  parameter int AF_THRESH = 6,
  localparam int VC_W     = calc_vc_w(NUM_VC),
  localparam int PTR_W    = calc_ptr_w(DEPTH),
  localparam int CNT_W    = calc_cnt_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [VC_W-1:0]         wr_vc,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    rd_en,
  input  logic [VC_W-1:0]         rd_vc,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_valid,
  output logic [NUM_VC-1:0]       full,
  output logic [NUM_VC-1:0]       empty,
  output logic [NUM_VC-1:0]       almost_full,
  output logic [NUM_VC*CNT_W-1:0] count,
  input  logic                    err_clr,
  output logic                    err_overflow,
  output logic                    err_underflow
);

  localparam int ADDR_W    = VC_W + PTR_W;
  localparam int MEM_DEPTH = NUM_VC * DEPTH;
  localparam logic [VC_W:0] NUM_VC_L = (VC_W + 1)'(NUM_VC);

  // Shared storage, addressed {vc, ptr}; contents are not reset.
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [PTR_W-1:0] head_arr [NUM_VC];
  logic [PTR_W-1:0] tail_arr [NUM_VC];
  logic [NUM_VC-1:0] wr_acc;
  logic [NUM_VC-1:0] rd_acc;

  logic            wr_vc_ok;
  logic            rd_vc_ok;
  logic [VC_W-1:0] wr_vc_idx;
  logic [VC_W-1:0] rd_vc_idx;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic            wr_acc_any;
  logic            rd_acc_any;

  logic err_overflow_reg;
  logic err_underflow_reg;

  // Out-of-range VC selects are treated as misses; the index is parked at 0
  // so array lookups stay in bounds.
  assign wr_vc_ok  = ({1'b0, wr_vc} < NUM_VC_L);
  assign rd_vc_ok  = ({1'b0, rd_vc} < NUM_VC_L);
  assign wr_vc_idx = wr_vc_ok ? wr_vc : '0;
  assign rd_vc_idx = rd_vc_ok ? rd_vc : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
      logic wr_hit;
      logic rd_hit;

      assign rd_hit     = rd_en && rd_vc_ok && (rd_vc == VC_W'(gi));
      assign wr_hit     = wr_en && wr_vc_ok && (wr_vc == VC_W'(gi));
      // A read only pops what was already queued; a same-cycle write to an
      // empty VC cannot satisfy it.
      assign rd_acc[gi] = rd_hit && !empty[gi];
      // A full VC still takes a write when the same cycle pops it.
      assign wr_acc[gi] = wr_hit && (!full[gi] || rd_acc[gi]);

      vc_fifo_ctrl #(
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH)
      ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .wr_acc      (wr_acc[gi]),
        .rd_acc      (rd_acc[gi]),
        .head        (head_arr[gi]),
        .tail        (tail_arr[gi]),
        .count       (count[gi*CNT_W +: CNT_W]),
        .full        (full[gi]),
        .empty       (empty[gi]),
        .almost_full (almost_full[gi])
      );
    end
  endgenerate

  assign wr_acc_any = |wr_acc;
  assign rd_acc_any = |rd_acc;
  assign wr_addr    = {wr_vc_idx, tail_arr[wr_vc_idx]};
  assign rd_addr    = {rd_vc_idx, head_arr[rd_vc_idx]};

  always_ff @(posedge clk) begin
    if (!rst && wr_acc_any) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Show-ahead read port: head flit of the selected VC, forced to zero
  // whenever there is nothing valid to present.
  assign rd_valid = rd_vc_ok && !empty[rd_vc_idx];
  assign rd_data  = rd_valid ? mem[rd_addr] : '0;

  // Sticky errors; a new error in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow_reg  <= 1'b0;
      err_underflow_reg <= 1'b0;
    end else begin
      if (wr_en && !wr_acc_any)      err_overflow_reg <= 1'b1;
      else if (err_clr)              err_overflow_reg <= 1'b0;
      if (rd_en && !rd_acc_any)      err_underflow_reg <= 1'b1;
      else if (err_clr)              err_underflow_reg <= 1'b0;
    end
  end

  assign err_overflow  = err_overflow_reg;
  assign err_underflow = err_underflow_reg;

endmodule

// File: tb/tb_vc_fifo_bank.sv
module tb_vc_fifo_bank;

  localparam int DATA_W    = 64;
  localparam int DEPTH     = 8;
  localparam int NUM_VC    = 4;
  localparam int AF_THRESH = 6;
  localparam int VC_W      = 2;
  localparam int CNT_W     = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    wr_en;
  logic [VC_W-1:0]         wr_vc;
  logic [DATA_W-1:0]       wr_data;
  logic                    rd_en;
  logic [VC_W-1:0]         rd_vc;
  logic [DATA_W-1:0]       rd_data;
  logic                    rd_valid;
  logic [NUM_VC-1:0]       full;
  logic [NUM_VC-1:0]       empty;
  logic [NUM_VC-1:0]       almost_full;
  logic [NUM_VC*CNT_W-1:0] count;
  logic                    err_clr;
  logic                    err_overflow;
  logic                    err_underflow;

  vc_fifo_bank #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .NUM_VC    (NUM_VC),
    .AF_THRESH (AF_THRESH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_vc         (wr_vc),
    .wr_data       (wr_data),
    .rd_en         (rd_en),
    .rd_vc         (rd_vc),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .count         (count),
    .err_clr       (err_clr),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: one plain queue per VC plus the two sticky flags.
  logic [DATA_W-1:0] mq [NUM_VC][$];
  bit exp_ovf;
  bit exp_unf;

  typedef struct {
    bit                valid;
    logic [DATA_W-1:0] data;
    int                vc;
    string             tag;
  } exp_t;

  exp_t exp_q [$];

  // Monitor: the read port is compared every cycle a stimulus entry exists.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_valid !== e.valid || rd_data !== e.data) begin
        failures++;
        $display("FAIL rd_%s vc=%0d: got valid=%0b data=%h, expected valid=%0b data=%h",
                 e.tag, e.vc, rd_valid, rd_data, e.valid, e.data);
      end else begin
        $display("txn rd_%s vc=%0d valid=%0b data=%h", e.tag, e.vc, rd_valid, rd_data);
      end
    end
  end

  task automatic check_status(input string tag);
    logic [NUM_VC*CNT_W-1:0] exp_cnt;
    logic [NUM_VC-1:0] exp_empty, exp_full, exp_af;
    for (int v = 0; v < NUM_VC; v++) begin
      exp_cnt[v*CNT_W +: CNT_W] = CNT_W'(mq[v].size());
      exp_empty[v] = (mq[v].size() == 0);
      exp_full[v]  = (mq[v].size() == DEPTH);
      exp_af[v]    = (mq[v].size() >= AF_THRESH);
    end
    checks++;
    if (count !== exp_cnt) begin
      failures++;
      $display("FAIL count_%s: got %h, expected %h", tag, count, exp_cnt);
    end
    checks++;
    if ({empty, full, almost_full} !== {exp_empty, exp_full, exp_af}) begin
      failures++;
      $display("FAIL flags_%s: got empty=%b full=%b af=%b, expected empty=%b full=%b af=%b",
               tag, empty, full, almost_full, exp_empty, exp_full, exp_af);
    end
    checks++;
    if ({err_overflow, err_underflow} !== {exp_ovf, exp_unf}) begin
      failures++;
      $display("FAIL err_%s: got ovf=%0b unf=%0b, expected ovf=%0b unf=%0b",
               tag, err_overflow, err_underflow, exp_ovf, exp_unf);
    end
  endtask

  // One clock of stimulus. Inputs are applied just after a rising edge; the
  // read port is judged at the falling edge, status just after the next rise.
  task automatic step(input bit we, input int wv, input logic [DATA_W-1:0] wd,
                      input bit re, input int rv, input bit clr, input string tag);
    exp_t e;
    bit rd_ok;
    bit wr_ok;
    wr_en   = we;
    wr_vc   = VC_W'(wv);
    wr_data = wd;
    rd_en   = re;
    rd_vc   = VC_W'(rv);
    err_clr = clr;

    e.valid = 1'b0;
    e.data  = '0;
    e.vc    = rv;
    e.tag   = tag;
    if (rv < NUM_VC) begin
      if (mq[rv].size() > 0) begin
        e.valid = 1'b1;
        e.data  = mq[rv][0];
      end
    end
    exp_q.push_back(e);

    rd_ok = re && e.valid;
    wr_ok = 1'b0;
    if (we && wv < NUM_VC) begin
      wr_ok = (mq[wv].size() < DEPTH) || (rd_ok && rv == wv);
    end

    if (rd_ok) void'(mq[rv].pop_front());
    if (wr_ok) mq[wv].push_back(wd);
    if (we && !wr_ok) exp_ovf = 1'b1;
    else if (clr)     exp_ovf = 1'b0;
    if (re && !rd_ok) exp_unf = 1'b1;
    else if (clr)     exp_unf = 1'b0;

    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    check_status(tag);
  endtask

  task automatic do_reset(input string tag);
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    wr_vc   = '0;
    rd_vc   = '0;
    wr_data = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int v = 0; v < NUM_VC; v++) mq[v].delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    check_status(tag);
  endtask

  initial begin
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    do_reset("reset");
    step(0, 0, '0, 0, 0, 0, "idle");
    step(0, 0, '0, 0, 3, 0, "idle3");

    // In-order delivery on VC2.
    step(1, 2, 64'hA1, 0, 2, 0, "w2");
    step(1, 2, 64'hA2, 0, 2, 0, "w2");
    step(1, 2, 64'hA3, 0, 2, 0, "w2");
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 2, 0, "r2");

    // Fill VC0, overflow, then pointer wraps while full.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 64'hC0 + 64'(i), 0, 0, 0, "fill0");
    step(1, 0, 64'hDEAD, 0, 0, 0, "ovf0");
    step(0, 0, '0, 0, 0, 1, "clr");
    for (int i = 0; i < 10 * DEPTH; i++)
      step(1, 0, 64'hB000 + 64'(i), 1, 0, 0, "wrap0");
    for (int i = 0; i < DEPTH; i++) step(0, 0, '0, 1, 0, 0, "drain0");

    // Independent traffic: write VC1 while popping a preloaded VC3.
    for (int i = 0; i < DEPTH; i++) step(1, 3, 64'h3300 + 64'(i), 0, 3, 0, "pre3");
    for (int i = 0; i < DEPTH; i++)
      step(1, 1, 64'h1100 + 64'(i), 1, 3, 0, "x13");
    for (int i = 0; i < DEPTH; i++) step(0, 0, '0, 1, 1, 0, "drain1");

    // Read of an empty VC is not rescued by a same-cycle write.
    step(1, 1, 64'h55, 1, 1, 0, "unf1");
    step(0, 0, '0, 0, 1, 0, "show1");
    step(0, 0, '0, 0, 1, 1, "clr");
    step(0, 0, '0, 1, 1, 0, "r1");

    // Reset discards queued flits.
    for (int i = 0; i < 5; i++) step(1, 3, 64'hE0 + 64'(i), 0, 3, 0, "load3");
    do_reset("midrst");
    step(1, 3, 64'h77, 0, 3, 0, "w3");
    step(0, 0, '0, 1, 3, 0, "r3");

    // Randomized mixed traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 60, int'($urandom_range(0, NUM_VC - 1)),
           {$urandom, $urandom},
           $urandom_range(0, 99) < 55, int'($urandom_range(0, NUM_VC - 1)),
           $urandom_range(0, 19) == 0, "rnd");
    end

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
